// File: rtl/alu_result_writeback.sv
// ---------------------------------------------------------------------------
// alu_result_writeback
//
// Result/flag writeback stage behind the 32-bit shift/ALU unit. Results,
// their destination register and the ALU flags are buffered in a 2-entry
// FIFO. When an entry is handed to the register-file write port, its flags
// are committed into the architectural status register.
//
// Optional feature macro: FLAG_STICKY_EN
//   defined   : stickyOverflow latches any committed overflow and clears on
//               clearSticky. A set and a clear in the same cycle leave it set.
//   undefined : stickyOverflow is tied to 0 and clearSticky is ignored.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   inValid / inReady    upstream handshake (inReady is registered)
//   inData, inAddr       result and destination register
//   inSetFlags           this result updates the status flags
//   inZero/inOverflow/inCarry/inNegative   ALU flags, sampled at push
//   outValid / outReady  register-file write handshake
//   outData, outAddr     head entry (0 while empty)
//   statusFlags          committed {N,Z,C,V}
//   occupancy            entries held, 0..2
//   clearSticky          clear request for stickyOverflow
//   stickyOverflow       sticky overflow indicator
// ---------------------------------------------------------------------------
module alu_result_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_WIDTH-1:0] inData,
  input  logic [ADDR_WIDTH-1:0] inAddr,
  input  logic                  inSetFlags,
  input  logic                  inZero,
  input  logic                  inOverflow,
  input  logic                  inCarry,
  input  logic                  inNegative,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outData,
  output logic [ADDR_WIDTH-1:0] outAddr,
  output logic [3:0]            statusFlags,
  output logic [1:0]            occupancy,
  input  logic                  clearSticky,
  output logic                  stickyOverflow
);

  // Entry storage; flags packed as {N,Z,C,V} to match statusFlags.
  logic [DATA_WIDTH-1:0] r_data [2];
  logic [ADDR_WIDTH-1:0] r_addr [2];
  logic [3:0]            r_nzcv [2];
  logic                  r_setf [2];

  logic       r_head;
  logic       r_tail;
  logic [1:0] r_occ;
  logic       r_in_ready;
  logic [3:0] r_status;

  logic       w_push;
  logic       w_pop;
  logic       w_not_empty;
  logic [1:0] w_occ_next;

  assign w_not_empty = (r_occ != 2'd0);
  assign w_push      = inValid && r_in_ready;
  assign w_pop       = w_not_empty && outReady;

  always_comb begin
    w_occ_next = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_next = r_occ + 2'd1;
      2'b01:   w_occ_next = r_occ - 2'd1;
      default: w_occ_next = r_occ;
    endcase
  end

  // Pointers, occupancy and the registered ready. inReady is computed from
  // the next occupancy, so a pop at full only reopens the input one cycle
  // later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_occ      <= 2'd0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_push) r_tail <= ~r_tail;
      if (w_pop)  r_head <= ~r_head;
      r_occ      <= w_occ_next;
      r_in_ready <= (w_occ_next < 2'd2);
    end
  end

  // Entry writes. Push never targets the head of a full FIFO, because
  // inReady is low at full, so a same-cycle pop never reads a slot being
  // overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_addr[i] <= '0;
        r_nzcv[i] <= 4'b0000;
        r_setf[i] <= 1'b0;
      end
    end else if (w_push) begin
      r_data[r_tail] <= inData;
      r_addr[r_tail] <= inAddr;
      r_nzcv[r_tail] <= {inNegative, inZero, inCarry, inOverflow};
      r_setf[r_tail] <= inSetFlags;
    end
  end

  // Status commit happens on the pop edge of a flag-setting entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= 4'b0000;
    end else if (w_pop && r_setf[r_head]) begin
      r_status <= r_nzcv[r_head];
    end
  end

`ifdef FLAG_STICKY_EN
  logic r_sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_pop && r_setf[r_head] && r_nzcv[r_head][0]) begin
      r_sticky <= 1'b1;
    end else if (clearSticky) begin
      r_sticky <= 1'b0;
    end
  end

  assign stickyOverflow = r_sticky;
`else
  logic w_unused_clear;
  assign w_unused_clear = clearSticky;
  assign stickyOverflow = 1'b0;
`endif

  // Empty FIFO presents zeros rather than stale or incoming data.
  assign outValid    = w_not_empty;
  assign outData     = w_not_empty ? r_data[r_head] : '0;
  assign outAddr     = w_not_empty ? r_addr[r_head] : '0;
  assign inReady     = r_in_ready;
  assign occupancy   = r_occ;
  assign statusFlags = r_status;

endmodule

// File: tb/tb_alu_result_writeback.sv
// ---------------------------------------------------------------------------
// tb_alu_result_writeback
//
// Bench for alu_result_writeback. Stimulus changes 1 time unit after each
// rising edge; a negedge monitor keeps a queue-based reference model of the
// stage, compares every visible output against it and advances the model by
// the handshakes that the coming rising edge will perform.
// ---------------------------------------------------------------------------
module tb_alu_result_writeback;

  logic        clk;
  logic        rst_n;
  logic        inValid;
  logic        inReady;
  logic [31:0] inData;
  logic [4:0]  inAddr;
  logic        inSetFlags;
  logic        inZero;
  logic        inOverflow;
  logic        inCarry;
  logic        inNegative;
  logic        outValid;
  logic        outReady;
  logic [31:0] outData;
  logic [4:0]  outAddr;
  logic [3:0]  statusFlags;
  logic [1:0]  occupancy;
  logic        clearSticky;
  logic        stickyOverflow;

  alu_result_writeback dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inValid        (inValid),
    .inReady        (inReady),
    .inData         (inData),
    .inAddr         (inAddr),
    .inSetFlags     (inSetFlags),
    .inZero         (inZero),
    .inOverflow     (inOverflow),
    .inCarry        (inCarry),
    .inNegative     (inNegative),
    .outValid       (outValid),
    .outReady       (outReady),
    .outData        (outData),
    .outAddr        (outAddr),
    .statusFlags    (statusFlags),
    .occupancy      (occupancy),
    .clearSticky    (clearSticky),
    .stickyOverflow (stickyOverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        setf;
    logic [3:0]  nzcv;
  } entry_t;

  entry_t q[$];
  logic [3:0] exp_status;
  logic       exp_sticky;
  logic       exp_ready;
  int         n_checks;
  int         n_errors;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model and scoreboard.
  always @(negedge clk) begin
    entry_t e;
    logic   do_pop;
    logic   do_push;
    if (!rst_n) begin
      q.delete();
      exp_status = 4'b0000;
      exp_sticky = 1'b0;
      exp_ready  = 1'b0;
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      chk("rst_outValid", 32'(outValid), 32'd0);
      chk("rst_inReady", 32'(inReady), 32'd0);
      chk("rst_outData", outData, 32'd0);
      chk("rst_status", 32'(statusFlags), 32'd0);
    end else begin
      chk("occupancy", 32'(occupancy), 32'(q.size()));
      chk("outValid", 32'(outValid), 32'(q.size() != 0));
      chk("inReady", 32'(inReady), 32'(exp_ready));
      chk("statusFlags", 32'(statusFlags), 32'(exp_status));
      chk("stickyOverflow", 32'(stickyOverflow), 32'(exp_sticky));
      if (q.size() != 0) begin
        chk("outData", outData, q[0].data);
        chk("outAddr", 32'(outAddr), 32'(q[0].addr));
      end
      do_pop  = (q.size() != 0) && outReady;
      do_push = inValid && exp_ready;
      if (do_pop) begin
        e = q.pop_front();
        if (e.setf) exp_status = e.nzcv;
      end
`ifdef FLAG_STICKY_EN
      if (do_pop && e.setf && e.nzcv[0]) exp_sticky = 1'b1;
      else if (clearSticky)              exp_sticky = 1'b0;
`endif
      if (do_push)
        q.push_back('{data: inData, addr: inAddr, setf: inSetFlags,
                      nzcv: {inNegative, inZero, inCarry, inOverflow}});
      exp_ready = (q.size() < 2);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one entry and hold it until accepted (bounded wait).
  task automatic push_one(input logic [31:0] d, input logic [4:0] a,
                          input logic s, input logic [3:0] nzcv);
    int   waited;
    logic seen;
    waited     = 0;
    inData     = d;
    inAddr     = a;
    inSetFlags = s;
    inNegative = nzcv[3];
    inZero     = nzcv[2];
    inCarry    = nzcv[1];
    inOverflow = nzcv[0];
    inValid    = 1'b1;
    do begin
      seen = inReady;
      @(posedge clk);
      #1;
      waited++;
    end while (!seen && waited < 20);
    inValid = 1'b0;
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL push_timeout: got inReady=0 for %0d cycles expected 1", waited);
    end
    $display("push data=%08h addr=%0d setf=%0b nzcv=%04b", d, a, s, nzcv);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    exp_status  = 4'b0000;
    exp_sticky  = 1'b0;
    exp_ready   = 1'b0;
    rst_n       = 1'b0;
    inValid     = 1'b0;
    inData      = '0;
    inAddr      = '0;
    inSetFlags  = 1'b0;
    inZero      = 1'b0;
    inOverflow  = 1'b0;
    inCarry     = 1'b0;
    inNegative  = 1'b0;
    outReady    = 1'b0;
    clearSticky = 1'b0;

    #2;
    chk("reset_inReady", 32'(inReady), 32'd0);
    chk("reset_occupancy", 32'(occupancy), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("ready_after_reset", 32'(inReady), 32'd1);

    // Single push with outReady high; flags N=1 Z=0 C=1 V=0.
    outReady = 1'b1;
    push_one(32'hF0F0_F0F0, 5'd3, 1'b1, 4'b1010);
    step(3);
    chk("status_single", 32'(statusFlags), 32'hA);

    // Fill under backpressure, then drain in order.
    outReady = 1'b0;
    push_one(32'hAAAA_0001, 5'd7, 1'b1, 4'b0100);
    push_one(32'hBBBB_0002, 5'd9, 1'b1, 4'b0010);
    step(3);
    chk("full_occupancy", 32'(occupancy), 32'd2);
    chk("full_inReady", 32'(inReady), 32'd0);
    chk("full_outData", outData, 32'hAAAA_0001);
    outReady = 1'b1;
    step(4);

    // Push while popping at occupancy 1.
    outReady = 1'b0;
    push_one(32'hDDDD_0003, 5'd1, 1'b1, 4'b0001);
    outReady = 1'b1;
    push_one(32'hCCCC_0004, 5'd2, 1'b0, 4'b0000);
    chk("simul_occupancy", 32'(occupancy), 32'd1);
    chk("simul_outData", outData, 32'hCCCC_0004);
    step(3);

    // setFlags=0 entry with Z=1 must not touch statusFlags.
    push_one(32'h0000_0000, 5'd4, 1'b0, 4'b0100);
    step(3);
    chk("noflags_status", 32'(statusFlags), 32'h1);

    // Sticky overflow: set and clear in the same cycle, then clear alone.
    outReady = 1'b0;
    push_one(32'h8000_0000, 5'd5, 1'b1, 4'b1001);
    outReady    = 1'b1;
    clearSticky = 1'b1;
    step(1);
    clearSticky = 1'b0;
    step(1);
    clearSticky = 1'b1;
    step(1);
    clearSticky = 1'b0;
    step(1);

    // Reset while full: outputs clear without a clock edge.
    outReady = 1'b0;
    push_one(32'h1111_1111, 5'd10, 1'b1, 4'b1111);
    push_one(32'h2222_2222, 5'd11, 1'b1, 4'b1111);
    rst_n = 1'b0;
    #1;
    chk("midrst_occupancy", 32'(occupancy), 32'd0);
    chk("midrst_outValid", 32'(outValid), 32'd0);
    chk("midrst_outData", outData, 32'd0);
    chk("midrst_outAddr", 32'(outAddr), 32'd0);
    chk("midrst_status", 32'(statusFlags), 32'd0);
    chk("midrst_sticky", 32'(stickyOverflow), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("midrst_ready_after", 32'(inReady), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      inValid     = ($urandom_range(3) != 0);
      outReady    = ($urandom_range(2) != 0);
      inData      = $urandom;
      inAddr      = 5'($urandom);
      inSetFlags  = 1'($urandom);
      inNegative  = 1'($urandom);
      inZero      = 1'($urandom);
      inCarry     = 1'($urandom);
      inOverflow  = 1'($urandom);
      clearSticky = ($urandom_range(7) == 0);
      step(1);
    end
    inValid     = 1'b0;
    clearSticky = 1'b0;
    outReady    = 1'b1;
    step(5);
    chk("drain_occupancy", 32'(occupancy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
